uart_rx_frame_check: RTL

//  Parametrised successor of the single-bit start-glitch checker: validates a whole UART RX frame
//  (start, DATA_WIDTH data bits LSB-first, optional parity, STOP_BITS stop bits) from one mid-bit

---
 rtl/uart_rx_frame_check.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_check.sv
// UART RX frame validator: checks start, data (LSB-first), optional parity and stop bits from one mid-bit sample each.
// Define UART_RX_ERR_CNT_EN to add saturating glitch/parity/stop error counters.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic                  start_detect,
    input  logic                  sampled_data,
    input  logic                  sampled_data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  busy,
    output logic                  start_glitch,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  data_valid,
`ifdef UART_RX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]  glitch_cnt,
    output logic [ERR_CNT_W-1:0]  par_err_cnt,
    output logic [ERR_CNT_W-1:0]  stp_err_cnt,
`endif
    output logic [DATA_WIDTH-1:0] p_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic                  stop_cnt_reg, stop_cnt_next;
    logic                  par_flag_reg, par_flag_next;
    logic                  stp_flag_reg, stp_flag_next;
    logic                  pe_reg, pe_next;
    logic                  pt_reg, pt_next;
    logic                  glitch_next, par_err_next, stp_err_next, dv_next;
    logic [DATA_WIDTH-1:0] p_data_next;
    logic                  stp_now;

    // Stop-error status including the sample currently on the input.
    assign stp_now = stp_flag_reg | ~sampled_data;

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        par_flag_next = par_flag_reg;
        stp_flag_next = stp_flag_reg;
        pe_next       = pe_reg;
        pt_next       = pt_reg;
        glitch_next   = 1'b0;
        par_err_next  = 1'b0;
        stp_err_next  = 1'b0;
        dv_next       = 1'b0;
        p_data_next   = p_data;
        case (state_reg)
            S_IDLE: begin
                if (start_detect) begin
                    state_next    = S_START;
                    pe_next       = par_en;
                    pt_next       = par_typ;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    par_flag_next = 1'b0;
                    stp_flag_next = 1'b0;
                end
            end
            S_START: begin
                if (sampled_data_valid) begin
                    if (sampled_data) begin
                        glitch_next = 1'b1;
                        state_next  = S_IDLE;
                    end else begin
                        state_next  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (sampled_data_valid) begin
                    shift_next = {sampled_data, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = pe_reg ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (sampled_data_valid) begin
                    par_flag_next = sampled_data != ((^shift_reg) ^ pt_reg);
                    state_next    = S_STOP;
                end
            end
            S_STOP: begin
                if (sampled_data_valid) begin
                    if (stop_cnt_reg == LAST_STOP) begin
                        state_next = S_IDLE;
                        if (!par_flag_reg && !stp_now) begin
                            dv_next     = 1'b1;
                            p_data_next = shift_reg;
                        end else begin
                            par_err_next = par_flag_reg;
                            stp_err_next = stp_now;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                        stp_flag_next = stp_now;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            state_reg    <= S_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            par_flag_reg <= 1'b0;
            stp_flag_reg <= 1'b0;
            pe_reg       <= 1'b0;
            pt_reg       <= 1'b0;
            busy         <= 1'b0;
            start_glitch <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            data_valid   <= 1'b0;
            p_data       <= '0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            par_flag_reg <= par_flag_next;
            stp_flag_reg <= stp_flag_next;
            pe_reg       <= pe_next;
            pt_reg       <= pt_next;
            busy         <= (state_next != S_IDLE);
            start_glitch <= glitch_next;
            par_err      <= par_err_next;
            stp_err      <= stp_err_next;
            data_valid   <= dv_next;
            p_data       <= p_data_next;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Index 0: start glitch, 1: parity error, 2: stop error.
    logic [2:0]           err_event;
    logic [ERR_CNT_W-1:0] err_cnt_reg [3];

    assign err_event = {stp_err_next, par_err_next, glitch_next};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_err_cnt
            always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
                if (!asy_reset) begin
                    err_cnt_reg[gi] <= '0;
                end else if (err_event[gi] && (err_cnt_reg[gi] != '1)) begin
                    err_cnt_reg[gi] <= err_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign glitch_cnt  = err_cnt_reg[0];
    assign par_err_cnt = err_cnt_reg[1];
    assign stp_err_cnt = err_cnt_reg[2];
`endif

endmodule
